// File: rtl/fft16_sched.sv
// fft16_sched
// Scheduler for a 16-point radix-2 decimation-in-frequency FFT that shares a
// single butterfly processing element (one outstanding operation at a time).
// It buffers 16 complex samples and runs 4 stages x 8 butterflies through the
// PE, writing each result pair back in place. It then streams the 16 results out.
//
// Parameters
//   DW     sample width, packed {re[15:0], im[15:0]} (fixed at 32)
//   PE_TO  watchdog limit in cycles for a PE answer (2..255)
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   din_valid, din      input sample stream; transfer when din_valid && din_ready
//   din_ready           high while idle or loading
//   busy                high in every state except idle
//   pe_a, pe_b          butterfly top/bottom operands to the PE
//   pe_power            twiddle index p (W16^p) to the PE
//   pe_ab_valid         one-cycle issue strobe to the PE
//   pe_fft_a, pe_fft_b  PE top/bottom results
//   pe_valid            PE result strobe (only honoured while waiting)
//   dout_valid, dout    output sample stream, 16 consecutive beats
//   done                pulses with the last output beat
//   err                 pulses when the PE fails to answer in time
//
// Build option
//   FFT16_NATORD_EN  when defined, results are emitted in natural frequency
//                    order. Otherwise they come out in DIF bit-reversed order.

module fft16_sched #(
  parameter int DW    = 32,
  parameter int PE_TO = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  output logic          din_ready,
  output logic          busy,
  output logic [DW-1:0] pe_a,
  output logic [DW-1:0] pe_b,
  output logic [2:0]    pe_power,
  output logic          pe_ab_valid,
  input  logic [DW-1:0] pe_fft_a,
  input  logic [DW-1:0] pe_fft_b,
  input  logic          pe_valid,
  output logic          dout_valid,
  output logic [DW-1:0] dout,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_OUT} state_t;

  localparam logic [7:0] WD_LIMIT = 8'(PE_TO - 1);

  state_t        state;
  logic [DW-1:0] mem [16];
  logic [3:0]    ld_cnt;
  logic [2:0]    k;
  logic [1:0]    s;
  logic [7:0]    wd;
  logic [3:0]    out_i;

  // Top index of a butterfly: a zero bit inserted into k at the position of
  // the stage's span (span = 8 >> s). The bottom index is top | span.
  function automatic logic [3:0] top_of(input logic [1:0] st, input logic [2:0] kk);
    case (st)
      2'd0:    top_of = {1'b0, kk};
      2'd1:    top_of = {kk[2], 1'b0, kk[1:0]};
      2'd2:    top_of = {kk[2:1], 1'b0, kk[0]};
      default: top_of = {kk, 1'b0};
    endcase
  endfunction

  function automatic logic [3:0] span_of(input logic [1:0] st);
    span_of = 4'd8 >> st;
  endfunction

  // Twiddle index (k mod span) << s, kept to 3 bits.
  function automatic logic [2:0] power_of(input logic [1:0] st, input logic [2:0] kk);
    case (st)
      2'd0:    power_of = kk;
      2'd1:    power_of = {kk[1:0], 1'b0};
      2'd2:    power_of = {kk[0], 2'b00};
      default: power_of = 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] out_addr(input logic [3:0] i);
`ifdef FFT16_NATORD_EN
    out_addr = {i[0], i[1], i[2], i[3]};
`else
    out_addr = i;
`endif
  endfunction

  logic       last_bf;
  logic [2:0] k_nx;
  logic [1:0] s_nx;
  logic [3:0] top_cur, bot_cur, top_nx, bot_nx;

  always_comb begin
    last_bf = (s == 2'd3) && (k == 3'd7);
    k_nx    = k + 3'd1;
    s_nx    = (k == 3'd7) ? s + 2'd1 : s;
    top_cur = top_of(s, k);
    bot_cur = top_cur | span_of(s);
    top_nx  = top_of(s_nx, k_nx);
    bot_nx  = top_nx | span_of(s_nx);
  end

  // Operands for the next butterfly are read on the same edge that writes back
  // the current results. This is safe because consecutive butterflies never
  // share an index, including across stage boundaries. All outputs are
  // registered, so each strobe and its data appear together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ld_cnt      <= 4'd0;
      k           <= 3'd0;
      s           <= 2'd0;
      wd          <= 8'd0;
      out_i       <= 4'd0;
      din_ready   <= 1'b1;
      busy        <= 1'b0;
      pe_a        <= '0;
      pe_b        <= '0;
      pe_power    <= 3'd0;
      pe_ab_valid <= 1'b0;
      dout_valid  <= 1'b0;
      dout        <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      pe_ab_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (din_valid) begin
            mem[0] <= din;
            ld_cnt <= 4'd1;
            busy   <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (din_valid) begin
            mem[ld_cnt] <= din;
            ld_cnt      <= ld_cnt + 4'd1;
            if (ld_cnt == 4'd15) begin
              din_ready   <= 1'b0;
              k           <= 3'd0;
              s           <= 2'd0;
              pe_ab_valid <= 1'b1;
              pe_a        <= mem[0];
              pe_b        <= mem[8];
              pe_power    <= 3'd0;
              state       <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // wd counts cycles elapsed since the issue cycle
          wd    <= 8'd1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (pe_valid) begin
            mem[top_cur] <= pe_fft_a;
            mem[bot_cur] <= pe_fft_b;
            if (last_bf) begin
              k          <= 3'd0;
              s          <= 2'd0;
              out_i      <= 4'd0;
              dout_valid <= 1'b1;
              dout       <= mem[out_addr(4'd0)];
              state      <= S_OUT;
            end else begin
              k           <= k_nx;
              s           <= s_nx;
              pe_ab_valid <= 1'b1;
              pe_a        <= mem[top_nx];
              pe_b        <= mem[bot_nx];
              pe_power    <= power_of(s_nx, k_nx);
              state       <= S_ISSUE;
            end
          end else if (wd >= WD_LIMIT) begin
            // PE never answered: abandon the transform
            err       <= 1'b1;
            k         <= 3'd0;
            s         <= 2'd0;
            wd        <= 8'd0;
            busy      <= 1'b0;
            din_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        S_OUT: begin
          if (out_i == 4'd15) begin
            out_i      <= 4'd0;
            dout_valid <= 1'b0;
            dout       <= '0;
            busy       <= 1'b0;
            din_ready  <= 1'b1;
            state      <= S_IDLE;
          end else begin
            out_i <= out_i + 4'd1;
            dout  <= mem[out_addr(out_i + 4'd1)];
            done  <= (out_i == 4'd14);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft16_sched.sv
// tb_fft16_sched
// Directed bench for fft16_sched. It uses a behavioural latency-1 butterfly PE
// with Q14 twiddles and floor rounding. Expected values are hand-computed
// constants.

module tb_fft16_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic [31:0] din;
  logic        din_ready;
  logic        busy;
  logic [31:0] pe_a, pe_b;
  logic [2:0]  pe_power;
  logic        pe_ab_valid;
  logic [31:0] pe_fft_a = '0;
  logic [31:0] pe_fft_b = '0;
  logic        pe_valid = 1'b0;
  logic        dout_valid;
  logic [31:0] dout;
  logic        done;
  logic        err;

  fft16_sched dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din(din), .din_ready(din_ready), .busy(busy),
    .pe_a(pe_a), .pe_b(pe_b), .pe_power(pe_power), .pe_ab_valid(pe_ab_valid),
    .pe_fft_a(pe_fft_a), .pe_fft_b(pe_fft_b), .pe_valid(pe_valid),
    .dout_valid(dout_valid), .dout(dout), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural PE: top = a + b, bottom = (a - b) * W16^p, Q14 twiddles.
  localparam longint COS_Q14 [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  localparam longint SIN_Q14 [8] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};

  function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] p);
    logic signed [15:0] ar, ai, br, bi, d_r, d_i;
    logic [15:0] sr, si;
    longint dr, di, mr, mi;
    ar = a[31:16]; ai = a[15:0];
    br = b[31:16]; bi = b[15:0];
    sr = ar + br;
    si = ai + bi;
    d_r = ar - br;
    d_i = ai - bi;
    dr = longint'(d_r);
    di = longint'(d_i);
    mr = (dr * COS_Q14[p] + di * SIN_Q14[p]) >>> 14;
    mi = (di * COS_Q14[p] - dr * SIN_Q14[p]) >>> 14;
    return {sr, si, mr[15:0], mi[15:0]};
  endfunction

  logic pe_en = 1'b1;

  always @(posedge clk) begin
    pe_valid <= 1'b0;
    if (pe_en && pe_ab_valid) begin
      pe_valid <= 1'b1;
      {pe_fft_a, pe_fft_b} <= bfly(pe_a, pe_b, pe_power);
    end
  end

  // Monitor: captures output beats, pulses and the issue trace on negedge
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        mon_clr = 1'b0;
  logic [31:0] out_buf [16];
  logic [31:0] tr_a [32];
  logic [31:0] tr_b [32];
  logic [2:0]  tr_p [32];
  int out_cnt, done_cnt, err_cnt, iss_cnt, done_idx, first_iss_cyc, err_cyc;

  always @(negedge clk) begin
    if (mon_clr) begin
      out_cnt = 0; done_cnt = 0; err_cnt = 0; iss_cnt = 0;
      done_idx = -1; first_iss_cyc = -1; err_cyc = -1;
      for (int i = 0; i < 16; i++) out_buf[i] = '0;
    end else begin
      if (dout_valid) begin
        if (out_cnt < 16) out_buf[out_cnt] = dout;
        if (done) done_idx = out_cnt;
        out_cnt++;
      end else if (done) begin
        done_idx = 99;
      end
      if (done) done_cnt++;
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (pe_ab_valid) begin
        if (iss_cnt < 32) begin
          tr_a[iss_cnt] = pe_a;
          tr_b[iss_cnt] = pe_b;
          tr_p[iss_cnt] = pe_power;
        end
        if (iss_cnt == 0) first_iss_cyc = cyc;
        iss_cnt++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [31:0] vec [16];

  // Loads vec[] into the DUT. With junk set, din_valid stays high carrying
  // garbage while the DUT is busy, until the first output beat appears.
  task automatic applyStimulus(input bit junk);
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b1;
      din       = vec[i];
      tick();
    end
    if (junk) begin
      din = 32'hDEAD_BEEF;
      for (int n = 0; n < 300 && out_cnt == 0; n++) tick();
    end
    din_valid = 1'b0;
    din       = '0;
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      tick();
      n++;
    end
    checkOutput({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
  endtask

  int nat1;

  initial begin
`ifdef FFT16_NATORD_EN
    nat1 = 1;
`else
    nat1 = 8;
`endif
    rst = 1'b1; din_valid = 1'b0; din = '0;
    tick(); tick(); tick();
    checkOutput("rst_busy",      32'(busy),        32'd0);
    checkOutput("rst_din_ready", 32'(din_ready),   32'd1);
    checkOutput("rst_ab_valid",  32'(pe_ab_valid), 32'd0);
    checkOutput("rst_dout_valid",32'(dout_valid),  32'd0);
    checkOutput("rst_done_err",  32'({done, err}), 32'd0);
    checkOutput("rst_dout",      dout,             32'd0);
    checkOutput("rst_pe_ab",     pe_a | pe_b,      32'd0);
    rst = 1'b0;
    tick();

    // Impulse with garbage on din while busy
    $display("[TB] impulse");
    for (int i = 0; i < 16; i++) vec[i] = '0;
    vec[0] = 32'h0100_0000;
    applyStimulus(1'b1);
    waitDone("imp");
    for (int i = 0; i < 16; i++) checkOutput($sformatf("imp_out%0d", i), out_buf[i], 32'h0100_0000);
    checkOutput("imp_done_idx", 32'(done_idx), 32'd15);
    checkOutput("imp_issues",   32'(iss_cnt),  32'd32);
    tick(); tick(); tick();
    checkOutput("imp_out_cnt",  32'(out_cnt),  32'd16);
    checkOutput("imp_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("imp_err_cnt",  32'(err_cnt),  32'd0);
    checkOutput("imp_idle",     32'({busy, din_ready}), 32'b01);

    // DC input
    $display("[TB] dc");
    for (int i = 0; i < 16; i++) vec[i] = 32'h0010_0000;
    applyStimulus(1'b0);
    waitDone("dc");
    checkOutput("dc_x0", out_buf[0], 32'h0100_0000);
    for (int i = 1; i < 16; i++) checkOutput($sformatf("dc_out%0d", i), out_buf[i], 32'h0);
    tick();

    // Issue trace with x[n] = {n, 0}
    $display("[TB] issue trace");
    for (int i = 0; i < 16; i++) vec[i] = {16'(i), 16'h0000};
    applyStimulus(1'b0);
    waitDone("trc");
    checkOutput("trc_s0k0_a", tr_a[0], 32'h0000_0000);
    checkOutput("trc_s0k0_b", tr_b[0], 32'h0008_0000);
    checkOutput("trc_s0k0_p", 32'(tr_p[0]), 32'd0);
    checkOutput("trc_s0k1_a", tr_a[1], 32'h0001_0000);
    checkOutput("trc_s0k1_b", tr_b[1], 32'h0009_0000);
    checkOutput("trc_s0k1_p", 32'(tr_p[1]), 32'd1);
    checkOutput("trc_s1k0_a", tr_a[8], 32'h0008_0000);
    checkOutput("trc_s1k0_b", tr_b[8], 32'h0010_0000);
    checkOutput("trc_s1k0_p", 32'(tr_p[8]), 32'd0);
    checkOutput("trc_s1k1_a", tr_a[9], 32'h000A_0000);
    checkOutput("trc_s1k1_b", tr_b[9], 32'h0012_0000);
    checkOutput("trc_s1k1_p", 32'(tr_p[9]), 32'd2);
    checkOutput("trc_s2k1_p", 32'(tr_p[17]), 32'd4);
    checkOutput("trc_s3k0_p", 32'(tr_p[24]), 32'd0);
    checkOutput("trc_s3k5_p", 32'(tr_p[29]), 32'd0);
    checkOutput("trc_issues", 32'(iss_cnt), 32'd32);
    tick();

    // Single tone at x[1]
    $display("[TB] tone x1");
    for (int i = 0; i < 16; i++) vec[i] = '0;
    vec[1] = 32'h0100_0000;
    applyStimulus(1'b0);
    waitDone("tone");
    checkOutput("tone_x0", out_buf[0], 32'h0100_0000);
    checkOutput("tone_x1", out_buf[nat1], 32'h00EC_FF9E);
    tick();

    // Watchdog: PE never answers
    $display("[TB] watchdog");
    pe_en = 1'b0;
    for (int i = 0; i < 16; i++) vec[i] = 32'h0001_0001;
    applyStimulus(1'b0);
    for (int n = 0; n < 100 && err_cnt == 0; n++) tick();
    checkOutput("wd_err_seen", 32'(err_cnt), 32'd1);
    checkOutput("wd_latency",  32'(err_cyc - first_iss_cyc), 32'd16);
    tick(); tick();
    checkOutput("wd_err_pulse", 32'(err_cnt), 32'd1);
    checkOutput("wd_issues",    32'(iss_cnt), 32'd1);
    checkOutput("wd_idle",      32'({busy, din_ready}), 32'b01);
    checkOutput("wd_no_out",    32'(out_cnt), 32'd0);
    pe_en = 1'b1;
    tick();

    // Reset in the middle of stage 2, then a clean run
    $display("[TB] reset mid-run");
    for (int i = 0; i < 16; i++) vec[i] = '0;
    vec[0] = 32'h0100_0000;
    applyStimulus(1'b0);
    for (int n = 0; n < 200 && iss_cnt < 17; n++) tick();
    checkOutput("mid_reached_s2", 32'(iss_cnt >= 17), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_idle",  32'({busy, din_ready}), 32'b01);
    checkOutput("mid_rst_quiet", 32'({pe_ab_valid, dout_valid, done}), 32'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) vec[i] = 32'h0010_0000;
    applyStimulus(1'b0);
    waitDone("mid");
    checkOutput("mid_x0",       out_buf[0], 32'h0100_0000);
    checkOutput("mid_x8",       out_buf[8], 32'h0);
    checkOutput("mid_done_idx", 32'(done_idx), 32'd15);
    checkOutput("mid_issues",   32'(iss_cnt),  32'd32);
    checkOutput("mid_err_cnt",  32'(err_cnt),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
